// File: rtl/id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_operand_stage
// Description : ID/EX pipeline register sitting directly after the 32x64
//               register file. Resolves both source operands with EX/MEM/WB
//               bypassing and a hard-wired zero register, and detects
//               load-use hazards (one-cycle stall plus one injected bubble).
//               The operands it hands to EX are final.
// Ports       :
//   clk            clock, all state updates on rising edge
//   reset          synchronous active-low reset
//   flush          taken branch: kill instruction entering EX
//   id_*           decoded instruction and register-file read data in ID
//   ex_alu_result  combinational ALU result of the instruction in EX
//   mem_*          MEM-stage write-back info (load data for loads)
//   wb_*           WB-stage write-back info (same as regfile write port)
//   stall          hold PC and IF/ID this cycle (combinational)
//   ex_*           registered EX-stage instruction fields
//   stall_cnt      saturating count of stall cycles
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_operand_stage #(
    parameter int DATA_W   = 64,
    parameter int REG_AW   = 5,
    parameter int ZERO_REG = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rn,
    input  logic [REG_AW-1:0] id_rm,
    input  logic              id_uses_rn,
    input  logic              id_uses_rm,
    input  logic [DATA_W-1:0] id_rd_data1,
    input  logic [DATA_W-1:0] id_rd_data2,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic              mem_regwrite,
    input  logic [REG_AW-1:0] mem_dest,
    input  logic [DATA_W-1:0] mem_fwd_data,
    input  logic              wb_regwrite,
    input  logic [REG_AW-1:0] wb_dest,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stall,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_opA,
    output logic [DATA_W-1:0] ex_opB,
    output logic [REG_AW-1:0] ex_dest,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic [31:0]       stall_cnt
);

    localparam logic [REG_AW-1:0] c_ZERO_IDX = REG_AW'(ZERO_REG);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic              ex_valid_q,    ex_valid_d;
    logic [DATA_W-1:0] ex_opA_q,      ex_opA_d;
    logic [DATA_W-1:0] ex_opB_q,      ex_opB_d;
    logic [REG_AW-1:0] ex_dest_q,     ex_dest_d;
    logic              ex_regwrite_q, ex_regwrite_d;
    logic              ex_memread_q,  ex_memread_d;
    logic [31:0]       stall_cnt_q,   stall_cnt_d;

    logic              w_haz;
    logic              w_stall;
    logic [DATA_W-1:0] w_opA;
    logic [DATA_W-1:0] w_opB;

    // ------------------------------------------------------------------
    // Operand resolution: zero register first, then youngest producer wins.
    // All inputs are explicit arguments so the function is purely local.
    // ------------------------------------------------------------------
    function automatic logic [DATA_W-1:0] resolve(
        input logic [REG_AW-1:0] src,
        input logic [DATA_W-1:0] rd_data,
        input logic              exv,
        input logic              exw,
        input logic [REG_AW-1:0] exd,
        input logic [DATA_W-1:0] exr,
        input logic              memw,
        input logic [REG_AW-1:0] memd,
        input logic [DATA_W-1:0] memr,
        input logic              wbw,
        input logic [REG_AW-1:0] wbd,
        input logic [DATA_W-1:0] wbr
    );
        logic [DATA_W-1:0] res;
        if (src == c_ZERO_IDX)                 res = '0;
        else if (exv && exw && (exd == src))   res = exr;
        else if (memw && (memd == src))        res = memr;
        else if (wbw && (wbd == src))          res = wbr;
        else                                   res = rd_data;
        return res;
    endfunction

    always_comb begin
        w_opA = resolve(id_rn, id_rd_data1, ex_valid_q, ex_regwrite_q, ex_dest_q,
                        ex_alu_result, mem_regwrite, mem_dest, mem_fwd_data,
                        wb_regwrite, wb_dest, wb_data);
        w_opB = resolve(id_rm, id_rd_data2, ex_valid_q, ex_regwrite_q, ex_dest_q,
                        ex_alu_result, mem_regwrite, mem_dest, mem_fwd_data,
                        wb_regwrite, wb_dest, wb_data);
    end

    // ------------------------------------------------------------------
    // Load-use hazard: load data only exists at the end of MEM, so a
    // dependent instruction in ID must wait one cycle and then pick the
    // value up from the MEM bypass. A load to the zero register produces
    // nothing anyone can depend on.
    // ------------------------------------------------------------------
    always_comb begin
        w_haz = ex_valid_q && ex_memread_q && (ex_dest_q != c_ZERO_IDX) && id_valid &&
                ((id_uses_rn && (id_rn == ex_dest_q)) ||
                 (id_uses_rm && (id_rm == ex_dest_q)));
        w_stall = w_haz && !flush && reset;
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        ex_valid_d    = ex_valid_q;
        ex_opA_d      = ex_opA_q;
        ex_opB_d      = ex_opB_q;
        ex_dest_d     = ex_dest_q;
        ex_regwrite_d = ex_regwrite_q;
        ex_memread_d  = ex_memread_q;
        stall_cnt_d   = stall_cnt_q;

        if (flush || w_stall) begin
            // Bubble: only the control bits matter; data fields just hold.
            ex_valid_d    = 1'b0;
            ex_regwrite_d = 1'b0;
            ex_memread_d  = 1'b0;
        end else begin
            ex_valid_d    = id_valid;
            ex_opA_d      = w_opA;
            ex_opB_d      = w_opB;
            ex_dest_d     = id_dest;
            ex_regwrite_d = id_valid && id_regwrite;
            ex_memread_d  = id_valid && id_memread;
        end

        if (w_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ex_valid_q    <= 1'b0;
            ex_opA_q      <= '0;
            ex_opB_q      <= '0;
            ex_dest_q     <= c_ZERO_IDX;
            ex_regwrite_q <= 1'b0;
            ex_memread_q  <= 1'b0;
            stall_cnt_q   <= '0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_opA_q      <= ex_opA_d;
            ex_opB_q      <= ex_opB_d;
            ex_dest_q     <= ex_dest_d;
            ex_regwrite_q <= ex_regwrite_d;
            ex_memread_q  <= ex_memread_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign stall       = w_stall;
    assign ex_valid    = ex_valid_q;
    assign ex_opA      = ex_opA_q;
    assign ex_opB      = ex_opB_q;
    assign ex_dest     = ex_dest_q;
    assign ex_regwrite = ex_regwrite_q;
    assign ex_memread  = ex_memread_q;
    assign stall_cnt   = stall_cnt_q;

endmodule
`default_nettype wire
